// File: rtl/bus_bridge_pkg.sv
// Shared definitions for the split-transaction bus bridge.
//   - default parameter constants for the bridge
//   - downstream sequencer state encoding
//   - request queue entry layout {we, addr, wdata, id}
package bus_bridge_pkg;

    localparam int              BB_ADDR_W      = 12;
    localparam int              BB_DATA_W      = 8;
    localparam int              BB_ID_W        = 2;
    localparam int              BB_DEPTH       = 4;
    localparam logic [11:0]     BB_B_BASE      = 12'h800;
    localparam logic [11:0]     BB_OFFSET_MASK = 12'h0FF;
    localparam int              BB_TIMEOUT_CYC = 64;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_RETURN    = 2'd3
    } bb_state_t;

    // Entry layout at the default widths; the queue itself stores the same
    // fields flattened so other widths can be used with bb_entry_w().
    typedef struct packed {
        logic                 we;
        logic [BB_ADDR_W-1:0] addr;
        logic [BB_DATA_W-1:0] wdata;
        logic [BB_ID_W-1:0]   id;
    } bb_entry_t;

    function automatic int bb_entry_w(input int addr_w, input int data_w, input int id_w);
        return 1 + addr_w + data_w + id_w;
    endfunction

endpackage

// File: rtl/bridge_req_fifo.sv
// Request queue for the bus bridge: a DEPTH-entry circular buffer.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   i_push / i_wdata    write an entry (ignored when full)
//   i_pop               drop the head entry (ignored when empty)
//   o_rdata             head entry (valid when !o_empty)
//   o_full / o_empty    occupancy flags
//   o_count             number of stored entries
module bridge_req_fifo #(
    parameter int W     = 23,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [W-1:0]           i_wdata,
    input  logic                   i_pop,
    output logic [W-1:0]           o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Payload storage needs no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bus_bridge_split_queue.sv
// Split-transaction bridge from upstream Bus A to downstream Bus B.
// Upstream requests are queued; a sequencer replays them on Bus B one at a
// time, in order. Reads return later on the a_rdata_* channel.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   IDLE       | no transaction in flight; launch queue head if present
//   REQ        | b_req held with stable b_* until b_ack or timeout
//   WAIT_DATA  | read accepted by Bus B, waiting for b_rdata_valid
//   RETURN     | read data presented upstream until a_rdata_ready
//
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   a_req/a_we/a_addr/a_wdata/a_id     upstream request
//   a_ack, a_split_ack                 accept (combinational), accept-as-read
//   a_rdata/a_rdata_id/a_rdata_valid   split read return, a_rdata_ready takes it
//   b_req/b_we/b_addr/b_wdata          Bus B request, b_ack accepts it
//   b_rdata/b_rdata_valid              Bus B read data
//   q_count                            queued entries (head stays queued while in flight)
//   err_timeout                        one-cycle pulse on downstream timeout
module bus_bridge_split_queue
    import bus_bridge_pkg::*;
#(
    parameter int                ADDR_W      = BB_ADDR_W,
    parameter int                DATA_W      = BB_DATA_W,
    parameter int                ID_W        = BB_ID_W,
    parameter int                DEPTH       = BB_DEPTH,
    parameter logic [ADDR_W-1:0] B_BASE      = BB_B_BASE,
    parameter logic [ADDR_W-1:0] OFFSET_MASK = BB_OFFSET_MASK,
    parameter int                TIMEOUT_CYC = BB_TIMEOUT_CYC,
    parameter logic [DATA_W-1:0] ERR_DATA    = '1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   a_req,
    input  logic                   a_we,
    input  logic [ADDR_W-1:0]      a_addr,
    input  logic [DATA_W-1:0]      a_wdata,
    input  logic [ID_W-1:0]        a_id,
    output logic                   a_ack,
    output logic                   a_split_ack,
    output logic [DATA_W-1:0]      a_rdata,
    output logic [ID_W-1:0]        a_rdata_id,
    output logic                   a_rdata_valid,
    input  logic                   a_rdata_ready,
    output logic                   b_req,
    output logic                   b_we,
    output logic [ADDR_W-1:0]      b_addr,
    output logic [DATA_W-1:0]      b_wdata,
    input  logic                   b_ack,
    input  logic [DATA_W-1:0]      b_rdata,
    input  logic                   b_rdata_valid,
    output logic [$clog2(DEPTH):0] q_count,
    output logic                   err_timeout
);

    localparam int               EW       = bb_entry_w(ADDR_W, DATA_W, ID_W);
    localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_tmo_hit;
    logic [EW-1:0]     w_push_entry;
    logic [EW-1:0]     w_head;
    logic              w_head_we;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_wdata;
    logic [ID_W-1:0]   w_head_id;

    bb_state_t         r_state;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_b_req;
    logic              r_b_we;
    logic [ADDR_W-1:0] r_b_addr;
    logic [DATA_W-1:0] r_b_wdata;
    logic [DATA_W-1:0] r_a_rdata;
    logic [ID_W-1:0]   r_a_rdata_id;
    logic              r_a_rdata_valid;
    logic              r_err;

    assign a_ack        = a_req && !w_full;
    assign a_split_ack  = a_ack && !a_we;
    assign w_push_entry = {a_we, a_addr, a_wdata, a_id};
    assign {w_head_we, w_head_addr, w_head_wdata, w_head_id} = w_head;

    // Down-counter loaded on entry to REQ/WAIT_DATA; zero is the last
    // allowed cycle, so the error lands TIMEOUT_CYC cycles after entry.
    assign w_tmo_hit = (r_tmo == '0);

    // The head stays queued until its transaction fully completes.
    assign w_pop = ((r_state == ST_REQ) && r_b_we && (b_ack || w_tmo_hit)) ||
                   ((r_state == ST_RETURN) && a_rdata_ready);

    bridge_req_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (a_ack),
        .i_wdata (w_push_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (q_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_tmo           <= '0;
            r_b_req         <= 1'b0;
            r_b_we          <= 1'b0;
            r_b_addr        <= '0;
            r_b_wdata       <= '0;
            r_a_rdata       <= '0;
            r_a_rdata_id    <= '0;
            r_a_rdata_valid <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_b_req   <= 1'b1;
                        r_b_we    <= w_head_we;
                        r_b_addr  <= (w_head_addr & OFFSET_MASK) | B_BASE;
                        r_b_wdata <= w_head_we ? w_head_wdata : '0;
                        r_tmo     <= TMO_LOAD;
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (b_ack) begin
                        r_b_req <= 1'b0;
                        if (r_b_we) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_tmo   <= TMO_LOAD;
                            r_state <= ST_WAIT_DATA;
                        end
                    end else if (w_tmo_hit) begin
                        r_err   <= 1'b1;
                        r_b_req <= 1'b0;
                        if (r_b_we) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_a_rdata       <= ERR_DATA;
                            r_a_rdata_id    <= w_head_id;
                            r_a_rdata_valid <= 1'b1;
                            r_state         <= ST_RETURN;
                        end
                    end else begin
                        r_tmo <= r_tmo - 1'b1;
                    end
                end
                ST_WAIT_DATA: begin
                    if (b_rdata_valid) begin
                        r_a_rdata       <= b_rdata;
                        r_a_rdata_id    <= w_head_id;
                        r_a_rdata_valid <= 1'b1;
                        r_state         <= ST_RETURN;
                    end else if (w_tmo_hit) begin
                        r_err           <= 1'b1;
                        r_a_rdata       <= ERR_DATA;
                        r_a_rdata_id    <= w_head_id;
                        r_a_rdata_valid <= 1'b1;
                        r_state         <= ST_RETURN;
                    end else begin
                        r_tmo <= r_tmo - 1'b1;
                    end
                end
                ST_RETURN: begin
                    if (a_rdata_ready) begin
                        r_a_rdata_valid <= 1'b0;
                        r_state         <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign b_req         = r_b_req;
    assign b_we          = r_b_we;
    assign b_addr        = r_b_addr;
    assign b_wdata       = r_b_wdata;
    assign a_rdata       = r_a_rdata;
    assign a_rdata_id    = r_a_rdata_id;
    assign a_rdata_valid = r_a_rdata_valid;
    assign err_timeout   = r_err;

endmodule
